// File: rtl/daq_pkg.sv
// Shared DAQ definitions: CRC appender states and CRC-16/CCITT-FALSE helper.
package daq_pkg;

   typedef enum logic [1:0] {ST_PASS, ST_CRC_HI, ST_CRC_LO} crc_state_t;

   localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
   localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

   // Advance a non-reflected, MSB-first CRC-16 by one byte.
   function automatic logic [15:0] crc16_byte(
      input logic [15:0] crc,
      input logic [7:0]  data_byte,
      input logic [15:0] poly
   );
      logic [15:0] c;
      c = crc ^ {data_byte, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ poly) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/axi_if.sv
// Byte-wise AXI-Stream bundle shared by the DAQ pipeline stages.
interface axi_if #(
   parameter int W = 8
);
   logic         tvalid;
   logic         tready;
   logic [W-1:0] tdata;
   logic         tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_pkt_crc_append.sv
// Passes packetizer bytes through a one-deep output slice and, when enabled
// for the packet, appends the CRC-16 (MSB first) with tlast moved onto it.
module axi_pkt_crc_append
   import daq_pkg::*;
#(
   parameter int          DATA_W     = 8,
   parameter logic [15:0] CRC_POLY   = CRC16_CCITT_POLY,
   parameter logic [15:0] CRC_INIT   = CRC16_CCITT_INIT,
   parameter logic [15:0] CRC_XOROUT = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   axi_if.slave        s_axi_if,
   axi_if.master       m_axi_if,
   input  logic        crc_en,
   output logic [15:0] pkt_count,
   output logic [15:0] crc_last
);

   if (DATA_W != 8) begin : g_bad_width
      $error("axi_pkt_crc_append: only DATA_W = 8 is supported");
   end

   crc_state_t  state, state_nxt;
   logic [15:0] crc, crc_nxt;
   logic [15:0] crc_final, crc_final_nxt;
   logic [15:0] crc_last_nxt;
   logic        sop, sop_nxt;
   logic        en_lat, en_lat_nxt;
   logic        valid_q, valid_nxt;
   logic [7:0]  data_q, data_nxt;
   logic        last_q, last_nxt;
   logic        s_ready;
   logic        slot_free;
   logic        en_now;
   logic [15:0] next_crc;

   assign slot_free = !valid_q || m_axi_if.tready;
   assign en_now    = sop ? crc_en : en_lat;
   assign next_crc  = crc16_byte(sop ? CRC_INIT : crc, s_axi_if.tdata, CRC_POLY);

   assign s_axi_if.tready = s_ready;
   assign m_axi_if.tvalid = rst_n & valid_q;
   assign m_axi_if.tdata  = rst_n ? data_q : 8'h00;
   assign m_axi_if.tlast  = rst_n & last_q;

   // Next-state logic: accept bytes in ST_PASS, then load the two CRC bytes
   // one per free slot so neither is skipped or duplicated under stall.
   always_comb begin
      state_nxt     = state;
      crc_nxt       = crc;
      crc_final_nxt = crc_final;
      crc_last_nxt  = crc_last;
      sop_nxt       = sop;
      en_lat_nxt    = en_lat;
      valid_nxt     = slot_free ? 1'b0 : valid_q;
      data_nxt      = data_q;
      last_nxt      = last_q;
      s_ready       = 1'b0;
      case (state)
         ST_PASS: begin
            s_ready = slot_free & rst_n;
            if (s_ready && s_axi_if.tvalid) begin
               valid_nxt = 1'b1;
               data_nxt  = s_axi_if.tdata;
               last_nxt  = 1'b0;
               crc_nxt   = next_crc;
               sop_nxt   = 1'b0;
               if (sop) begin
                  en_lat_nxt = crc_en;
               end
               if (s_axi_if.tlast) begin
                  if (en_now) begin
                     crc_final_nxt = next_crc ^ CRC_XOROUT;
                     state_nxt     = ST_CRC_HI;
                  end else begin
                     last_nxt = 1'b1;
                     sop_nxt  = 1'b1;
                  end
               end
            end
         end
         ST_CRC_HI: begin
            if (slot_free) begin
               valid_nxt = 1'b1;
               data_nxt  = crc_final[15:8];
               last_nxt  = 1'b0;
               state_nxt = ST_CRC_LO;
            end
         end
         ST_CRC_LO: begin
            if (slot_free) begin
               valid_nxt    = 1'b1;
               data_nxt     = crc_final[7:0];
               last_nxt     = 1'b1;
               crc_last_nxt = crc_final;
               crc_nxt      = CRC_INIT;
               sop_nxt      = 1'b1;
               state_nxt    = ST_PASS;
            end
         end
         default: state_nxt = ST_PASS;
      endcase
   end

   // State, CRC and output-slice registers; reset drops any in-flight bytes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_PASS;
         crc       <= CRC_INIT;
         crc_final <= 16'h0000;
         crc_last  <= 16'h0000;
         sop       <= 1'b1;
         en_lat    <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= 8'h00;
         last_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         crc       <= crc_nxt;
         crc_final <= crc_final_nxt;
         crc_last  <= crc_last_nxt;
         sop       <= sop_nxt;
         en_lat    <= en_lat_nxt;
         valid_q   <= valid_nxt;
         data_q    <= data_nxt;
         last_q    <= last_nxt;
      end
   end

   // Count packets as they leave, i.e. on the output handshake carrying tlast.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_count <= 16'h0000;
      end else if (valid_q && m_axi_if.tready && last_q) begin
         pkt_count <= pkt_count + 16'h0001;
      end
   end

endmodule

// File: tb/tb_axi_pkt_crc_append.sv
// Directed bench for axi_pkt_crc_append: known CRC vectors, pass-through,
// single-byte packet, reset mid-packet, random back-pressure and count wrap.
module tb_axi_pkt_crc_append;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        crc_en = 1'b0;
   logic [15:0] pkt_count;
   logic [15:0] crc_last;

   axi_if s_if ();
   axi_if m_if ();

   axi_pkt_crc_append dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_axi_if (s_if),
      .m_axi_if (m_if),
      .crc_en   (crc_en),
      .pkt_count(pkt_count),
      .crc_last (crc_last)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   bit          rand_ready = 1'b0;
   logic [8:0]  out_q[$];
   logic [8:0]  exp_q[$];
   logic [7:0]  pay[$];
   logic [7:0]  rx[$];
   logic [15:0] exp_cnt = 16'h0000;

   logic       pv_rst = 1'b0, pv_valid = 1'b0, pv_ready = 1'b0, pv_last = 1'b0;
   logic [7:0] pv_data = 8'h00;
   logic       ps_rst = 1'b0, ps_valid = 1'b0, ps_ready = 1'b0, ps_last = 1'b0;
   logic [7:0] ps_data = 8'h00;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Bit-serial reference CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF).
   function automatic logic [15:0] model_crc(input logic [7:0] bytes[$]);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (bytes[k]) begin
         for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ bytes[k][i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output back-pressure: always ready, or a coin flip each cycle.
   always @(posedge clk) begin
      #1;
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Record every output byte whose handshake completes at the next edge.
   always @(negedge clk) begin
      if (rst_n && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
         out_q.push_back({m_if.tlast, m_if.tdata});
      end
   end

   // Stalled beats on either side must not change until accepted.
   always @(negedge clk) begin
      if (rst_n && pv_rst && pv_valid && !pv_ready) begin
         check_value("m_stall_hold", {7'b0, m_if.tvalid, m_if.tlast, m_if.tdata},
                     {7'b0, 1'b1, pv_last, pv_data});
      end
      if (rst_n && ps_rst && ps_valid && !ps_ready) begin
         check_value("s_stall_hold", {7'b0, s_if.tvalid, s_if.tlast, s_if.tdata},
                     {7'b0, 1'b1, ps_last, ps_data});
      end
      pv_rst   = rst_n;
      pv_valid = m_if.tvalid;
      pv_ready = m_if.tready;
      pv_last  = m_if.tlast;
      pv_data  = m_if.tdata;
      ps_rst   = rst_n;
      ps_valid = s_if.tvalid;
      ps_ready = s_if.tready;
      ps_last  = s_if.tlast;
      ps_data  = s_if.tdata;
   end

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n;
      s_if.tvalid = 1'b1;
      s_if.tdata  = b;
      s_if.tlast  = last;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (s_if.tready !== 1'b1 && n < 200);
      if (n >= 200) check_value("s_ready_timeout", 16'(n), 16'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic en);
      crc_en = en;
      foreach (pay[i]) send_byte(pay[i], i == pay.size() - 1);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic check_output(input string tag);
      int n;
      n = 0;
      while (out_q.size() < exp_q.size() && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (out_q.size() < exp_q.size()) begin
         check_value({tag, "_timeout"}, 16'(out_q.size()), 16'(exp_q.size()));
      end
      rx.delete();
      foreach (exp_q[i]) begin
         if (out_q.size() > 0) begin
            check_value($sformatf("%s_byte%0d", tag, i), {7'b0, out_q[0]}, {7'b0, exp_q[i]});
            rx.push_back(out_q[0][7:0]);
            void'(out_q.pop_front());
         end
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      check_value({tag, "_pkt_count"}, pkt_count, exp_cnt);
   endtask

   task automatic expect_payload(input logic last_on_data);
      foreach (pay[i]) exp_q.push_back({last_on_data && (i == pay.size() - 1), pay[i]});
   endtask

   task automatic load_digits();
      pay.delete();
      for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_m_tvalid"}, {15'b0, m_if.tvalid}, 16'h0000);
      check_value({tag, "_m_tdata"},  {8'b0, m_if.tdata},   16'h0000);
      check_value({tag, "_m_tlast"},  {15'b0, m_if.tlast},  16'h0000);
      check_value({tag, "_s_tready"}, {15'b0, s_if.tready}, 16'h0000);
      check_value({tag, "_pkt_count"}, pkt_count, 16'h0000);
      check_value({tag, "_crc_last"},  crc_last,  16'h0000);
   endtask

   initial begin
      logic [15:0] c;
      int          len;

      s_if.tvalid = 1'b0;
      s_if.tdata  = 8'h00;
      s_if.tlast  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // "123456789" with CRC appended
      load_digits();
      apply_stimulus(1'b1);
      expect_payload(1'b0);
      exp_q.push_back({1'b0, 8'h29});
      exp_q.push_back({1'b1, 8'hB1});
      exp_cnt++;
      check_output("crc_digits");
      check_value("crc_digits_crc_last", crc_last, 16'h29B1);

      // Same packet passed through verbatim
      apply_stimulus(1'b0);
      expect_payload(1'b1);
      exp_cnt++;
      check_output("pass_digits");
      check_value("pass_digits_crc_last", crc_last, 16'h29B1);

      // Single-byte packet 0x00: CRC from 0xFFFF is 0xE1F0
      pay.delete();
      pay.push_back(8'h00);
      apply_stimulus(1'b1);
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'hE1});
      exp_q.push_back({1'b1, 8'hF0});
      exp_cnt++;
      check_output("single");
      check_value("single_crc_last", crc_last, 16'hE1F0);

      // Reset for one cycle after byte 5 of 9
      crc_en = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b0);
      s_if.tvalid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      out_q.delete();
      exp_cnt = 16'h0000;
      load_digits();
      apply_stimulus(1'b1);
      expect_payload(1'b0);
      exp_q.push_back({1'b0, 8'h29});
      exp_q.push_back({1'b1, 8'hB1});
      exp_cnt++;
      check_output("after_reset");
      check_value("after_reset_crc_last", crc_last, 16'h29B1);

      // Random back-pressure over 20 packets of 1..40 bytes
      rand_ready = 1'b1;
      for (int p = 0; p < 20; p++) begin
         len = $urandom_range(1, 40);
         pay.delete();
         for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
         c = model_crc(pay);
         apply_stimulus(1'b1);
         expect_payload(1'b0);
         exp_q.push_back({1'b0, c[15:8]});
         exp_q.push_back({1'b1, c[7:0]});
         exp_cnt++;
         check_output($sformatf("rand%0d", p));
         check_value($sformatf("rand%0d_crc_last", p), crc_last, c);
         check_value($sformatf("rand%0d_residue", p), model_crc(rx), 16'h0000);
      end
      rand_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Packet counter wrap from 0xFFFF
      @(negedge clk);
      force dut.pkt_count = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.pkt_count;
      pay.delete();
      pay.push_back(8'hA5);
      apply_stimulus(1'b0);
      expect_payload(1'b1);
      exp_cnt = 16'h0000;
      check_output("wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
